// File: rtl/flicker_range_engine_if.sv
// Toggle-handshake byte link between a host and the flicker range engine.
// The host drives the *_i signals and the engine drives the *_o signals.
interface flicker_range_engine_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] rx_data_i;
  logic              rx_byte_tgl_i;
  logic              rx_byte_ack_o;
  logic              rx_word_ack_o;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_byte_tgl_o;
  logic              tx_byte_ack_i;
  logic              tx_word_tgl_o;
  logic              busy_o;
  logic              done_o;
  logic [CNT_W:0]    emitted_o;

  modport master (
    output rx_data_i, rx_byte_tgl_i, tx_byte_ack_i,
    input  rx_byte_ack_o, rx_word_ack_o, tx_data_o, tx_byte_tgl_o,
           tx_word_tgl_o, busy_o, done_o, emitted_o
  );

  modport slave (
    input  rx_data_i, rx_byte_tgl_i, tx_byte_ack_i,
    output rx_byte_ack_o, rx_word_ack_o, tx_data_o, tx_byte_tgl_o,
           tx_word_tgl_o, busy_o, done_o, emitted_o
  );
endinterface

// File: rtl/flicker_range_engine.sv
// Receives a {start,end} word and a {step,flags} word over a toggle handshake,
// then streams every in-range value MSB-first without ever wrapping around.
module flicker_range_engine #(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst_n,
  flicker_range_engine_if.slave bus
);
  localparam int W      = DATA_W * WORD_BYTES;
  localparam int BCNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    RX_A, RX_B, CHECK, SEND, WAIT_ACK, NEXT, DONE
  } state_t;

  state_t state_q, state_d;

  logic              rx_tgl_q;
  logic              rx_byte_ack_q;
  logic              rx_word_ack_q;
  logic [BCNT_W-1:0] rx_cnt_q;
  logic [BCNT_W-1:0] tx_cnt_q;
  logic [W-1:0]      asm_q;
  logic [W-1:0]      asm_next;
  logic [W-1:0]      tx_shift_q;
  logic [CNT_W-1:0]  start_q;
  logic [CNT_W-1:0]  end_q;
  logic [CNT_W-1:0]  step_q;
  logic              dir_q;
  logic              incl_q;
  logic [CNT_W-1:0]  v_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_byte_tgl_q;
  logic              tx_word_tgl_q;
  logic [CNT_W:0]    emitted_q;

  logic              rx_accept;
  logic              rx_last;
  logic              tx_consumed;
  logic              tx_last;
  logic              start_ok;
  logic              next_ok;
  logic [CNT_W:0]    next_wide;

  function automatic logic in_range(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] lim,
                                    input logic down,
                                    input logic incl);
    if (down) return incl ? (val >= lim) : (val > lim);
    else      return incl ? (val <= lim) : (val < lim);
  endfunction

  // A pending rx toggle is only taken while collecting words; otherwise it waits.
  assign rx_accept   = (bus.rx_byte_tgl_i != rx_tgl_q) && ((state_q == RX_A) || (state_q == RX_B));
  assign rx_last     = (rx_cnt_q == LAST_BYTE);
  assign tx_consumed = (bus.tx_byte_ack_i == tx_byte_tgl_q);
  assign tx_last     = (tx_cnt_q == LAST_BYTE);
  assign asm_next    = (asm_q << DATA_W) | W'(bus.rx_data_i);
  assign start_ok    = in_range(start_q, end_q, dir_q, incl_q);

  // The extra top bit catches carry (up) or borrow (down) so nothing wraps.
  assign next_wide = dir_q ? ({1'b0, v_q} - {1'b0, step_q})
                           : ({1'b0, v_q} + {1'b0, step_q});
  assign next_ok   = !next_wide[CNT_W] && in_range(next_wide[CNT_W-1:0], end_q, dir_q, incl_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RX_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_A:     if (rx_accept && rx_last) state_d = RX_B;
      RX_B:     if (rx_accept && rx_last) state_d = CHECK;
      CHECK:    state_d = start_ok ? SEND : DONE;
      SEND:     state_d = WAIT_ACK;
      WAIT_ACK: if (tx_consumed) state_d = tx_last ? NEXT : SEND;
      NEXT:     state_d = next_ok ? SEND : DONE;
      DONE:     state_d = RX_A;
      default:  state_d = RX_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_tgl_q      <= bus.rx_byte_tgl_i;
      rx_byte_ack_q <= 1'b0;
      rx_word_ack_q <= 1'b0;
      rx_cnt_q      <= '0;
      tx_cnt_q      <= '0;
      asm_q         <= '0;
      tx_shift_q    <= '0;
      start_q       <= '0;
      end_q         <= '0;
      step_q        <= CNT_W'(1);
      dir_q         <= 1'b0;
      incl_q        <= 1'b0;
      v_q           <= '0;
      tx_data_q     <= '0;
      tx_byte_tgl_q <= 1'b0;
      tx_word_tgl_q <= 1'b0;
      emitted_q     <= '0;
    end else begin
      if (rx_accept) begin
        asm_q         <= asm_next;
        rx_tgl_q      <= bus.rx_byte_tgl_i;
        rx_byte_ack_q <= ~rx_byte_ack_q;
        if (rx_last) begin
          rx_cnt_q      <= '0;
          rx_word_ack_q <= ~rx_word_ack_q;
          if (state_q == RX_A) begin
            start_q <= asm_next[2*CNT_W-1:CNT_W];
            end_q   <= asm_next[CNT_W-1:0];
          end else begin
            step_q <= (asm_next[2*CNT_W-1:CNT_W] == '0) ? CNT_W'(1) : asm_next[2*CNT_W-1:CNT_W];
            dir_q  <= asm_next[0];
            incl_q <= asm_next[1];
          end
        end else begin
          rx_cnt_q <= rx_cnt_q + BCNT_W'(1);
        end
      end

      case (state_q)
        CHECK: begin
          v_q        <= start_q;
          tx_shift_q <= W'(start_q);
          tx_cnt_q   <= '0;
          emitted_q  <= '0;
        end
        SEND: begin
          tx_data_q     <= tx_shift_q[W-1 -: DATA_W];
          tx_shift_q    <= tx_shift_q << DATA_W;
          tx_byte_tgl_q <= ~tx_byte_tgl_q;
        end
        WAIT_ACK: begin
          if (tx_consumed) begin
            if (tx_last) begin
              tx_cnt_q      <= '0;
              tx_word_tgl_q <= ~tx_word_tgl_q;
              emitted_q     <= emitted_q + (CNT_W+1)'(1);
            end else begin
              tx_cnt_q <= tx_cnt_q + BCNT_W'(1);
            end
          end
        end
        NEXT: begin
          if (next_ok) begin
            v_q        <= next_wide[CNT_W-1:0];
            tx_shift_q <= W'(next_wide[CNT_W-1:0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_byte_ack_o = rx_byte_ack_q;
  assign bus.rx_word_ack_o = rx_word_ack_q;
  assign bus.tx_data_o     = tx_data_q;
  assign bus.tx_byte_tgl_o = tx_byte_tgl_q;
  assign bus.tx_word_tgl_o = tx_word_tgl_q;
  assign bus.busy_o        = (state_q != RX_A);
  assign bus.done_o        = (state_q == DONE);
  assign bus.emitted_o     = emitted_q;
endmodule

// File: tb/tb_flicker_range_engine.sv
// Directed bench for flicker_range_engine: table of range commands plus
// hand-written sequences for delayed acks, pending rx bytes and mid-stream reset.
module tb_flicker_range_engine;
  logic clk;
  logic rst_n;

  flicker_range_engine_if #(.DATA_W(8), .CNT_W(16)) bus ();

  flicker_range_engine #(.DATA_W(8), .WORD_BYTES(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vals packs up to four expected values, vals[0] being the first emitted.
  typedef struct packed {
    logic [15:0]       start_v;
    logic [15:0]       end_v;
    logic [15:0]       step_v;
    logic [15:0]       flags_v;
    logic [2:0]        n;
    logic [3:0][15:0]  vals;
  } vec_t;

  vec_t        vecs[7];
  int          checks;
  int          errors;
  logic        word_lvl;
  logic [31:0] got_vals[$];
  int          byte_tgls;
  int          word_tgls;
  int          done_pulses;
  int          first_tgl_cycle;
  int          hold_errs;
  logic        rx_ack_moved;
  logic        timed_out;

  task automatic checkOutput(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s (case %0d): got 0x%0h, expected 0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic checkResetState(input int idx);
    checkOutput("rst_busy", idx, 32'(bus.busy_o), 32'd0);
    checkOutput("rst_done", idx, 32'(bus.done_o), 32'd0);
    checkOutput("rst_emitted", idx, 32'(bus.emitted_o), 32'd0);
    checkOutput("rst_tx_data", idx, 32'(bus.tx_data_o), 32'd0);
    checkOutput("rst_toggles", idx,
                {28'd0, bus.rx_byte_ack_o, bus.rx_word_ack_o, bus.tx_byte_tgl_o, bus.tx_word_tgl_o}, 32'd0);
  endtask

  // Reset lasts exactly one rising edge; host toggle levels restart at zero.
  task automatic doReset(input int idx);
    rst_n             = 1'b0;
    bus.rx_byte_tgl_i = 1'b0;
    bus.tx_byte_ack_i = 1'b0;
    bus.rx_data_i     = 8'h00;
    word_lvl          = 1'b0;
    @(negedge clk);
    checkResetState(idx);
    rst_n = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    logic acked;
    acked = 1'b0;
    @(negedge clk);
    bus.rx_data_i     = b;
    bus.rx_byte_tgl_i = ~bus.rx_byte_tgl_i;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (bus.rx_byte_ack_o == bus.rx_byte_tgl_i) acked = 1'b1;
    end
    checkOutput("rx_byte_ack", 0, 32'(bus.rx_byte_ack_o), 32'(bus.rx_byte_tgl_i));
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) sendByte(w[i*8 +: 8]);
    word_lvl = ~word_lvl;
    checkOutput("rx_word_ack", 0, 32'(bus.rx_word_ack_o), 32'(word_lvl));
  endtask

  // Host side of the tx link; stops early at abortAt bytes without acking it.
  task automatic runStream(input int ackDelay, input bit injectRx, input int abortAt);
    logic        prev_byte, prev_word, done_seen, rx_ack_ref;
    logic [7:0]  held_data;
    logic [31:0] cur_word;
    int          wait_cnt, tail;
    got_vals.delete();
    byte_tgls       = 0;
    word_tgls       = 0;
    done_pulses     = 0;
    first_tgl_cycle = -1;
    hold_errs       = 0;
    rx_ack_moved    = 1'b0;
    done_seen       = 1'b0;
    prev_byte       = bus.tx_byte_tgl_o;
    prev_word       = bus.tx_word_tgl_o;
    rx_ack_ref      = bus.rx_byte_ack_o;
    held_data       = bus.tx_data_o;
    cur_word        = '0;
    wait_cnt        = 0;
    tail            = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (bus.done_o) begin
        done_pulses++;
        done_seen = 1'b1;
      end
      if (bus.tx_word_tgl_o != prev_word) begin
        word_tgls++;
        prev_word = bus.tx_word_tgl_o;
      end
      if (bus.tx_byte_tgl_o != prev_byte) begin
        byte_tgls++;
        prev_byte = bus.tx_byte_tgl_o;
        if (first_tgl_cycle < 0) first_tgl_cycle = cyc;
        cur_word  = {cur_word[23:0], bus.tx_data_o};
        held_data = bus.tx_data_o;
        wait_cnt  = ackDelay;
        if (byte_tgls % 4 == 0) got_vals.push_back(cur_word);
        if (injectRx && byte_tgls == 2) begin
          bus.rx_data_i     = 8'hA5;
          bus.rx_byte_tgl_i = ~bus.rx_byte_tgl_i;
        end
        if (abortAt != 0 && byte_tgls == abortAt) begin
          timed_out = 1'b0;
          return;
        end
      end
      if (!done_seen && bus.rx_byte_ack_o != rx_ack_ref) rx_ack_moved = 1'b1;
      if (bus.tx_byte_tgl_o != bus.tx_byte_ack_i) begin
        if (bus.tx_data_o != held_data) hold_errs++;
        if (wait_cnt == 0) bus.tx_byte_ack_i = bus.tx_byte_tgl_o;
        else wait_cnt--;
      end
      if (done_seen) begin
        tail++;
        if (tail == 4) break;
      end
    end
    timed_out = !done_seen;
  endtask

  task automatic applyStimulus(input vec_t v);
    sendWord({v.start_v, v.end_v});
    sendWord({v.step_v, v.flags_v});
    runStream(0, 1'b0, 0);
  endtask

  task automatic checkCommand(input vec_t v, input int idx);
    checkOutput("timeout", idx, 32'(timed_out), 32'd0);
    checkOutput("value_count", idx, 32'(got_vals.size()), 32'(v.n));
    for (int i = 0; i < int'(v.n); i++)
      checkOutput("value", idx, (i < got_vals.size()) ? got_vals[i] : 32'hDEAD_BEEF, {16'h0000, v.vals[i]});
    checkOutput("byte_toggles", idx, 32'(byte_tgls), 32'(4 * int'(v.n)));
    checkOutput("word_toggles", idx, 32'(word_tgls), 32'(v.n));
    checkOutput("done_pulses", idx, 32'(done_pulses), 32'd1);
    checkOutput("emitted", idx, 32'(bus.emitted_o), 32'(v.n));
    checkOutput("busy_idle", idx, 32'(bus.busy_o), 32'd0);
    if (v.n != 0) checkOutput("first_tx_latency", idx, 32'(first_tgl_cycle), 32'd2);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    word_lvl          = 1'b0;
    timed_out         = 1'b0;
    bus.rx_data_i     = 8'h00;
    bus.rx_byte_tgl_i = 1'b0;
    bus.tx_byte_ack_i = 1'b0;

    // start, end, step, flags, count, {unused.., third, second, first}
    vecs[0] = '{16'h0003, 16'h0006, 16'h0001, 16'h0000, 3'd3, {16'h0, 16'h0005, 16'h0004, 16'h0003}};
    vecs[1] = '{16'h000A, 16'h0004, 16'h0003, 16'h0003, 3'd3, {16'h0, 16'h0004, 16'h0007, 16'h000A}};
    vecs[2] = '{16'hFFFE, 16'hFFFF, 16'h0002, 16'h0002, 3'd1, {16'h0, 16'h0, 16'h0, 16'hFFFE}};
    vecs[3] = '{16'h0005, 16'h0005, 16'h0000, 16'h0000, 3'd0, {16'h0, 16'h0, 16'h0, 16'h0}};
    vecs[4] = '{16'h0005, 16'h0007, 16'h0000, 16'h0000, 3'd2, {16'h0, 16'h0, 16'h0006, 16'h0005}};
    vecs[5] = '{16'h0002, 16'h0000, 16'h0001, 16'hFFF1, 3'd2, {16'h0, 16'h0, 16'h0001, 16'h0002}};
    vecs[6] = '{16'h0001, 16'h0000, 16'h0003, 16'h0003, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0001}};

    repeat (3) @(negedge clk);
    checkResetState(100);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkCommand(vecs[i], i);
    end

    // Slow host acks plus an rx byte arriving mid-stream that must wait for RX_A.
    sendWord({vecs[0].start_v, vecs[0].end_v});
    sendWord({vecs[0].step_v, vecs[0].flags_v});
    runStream(10, 1'b1, 0);
    checkCommand(vecs[0], 200);
    checkOutput("tx_hold", 200, 32'(hold_errs), 32'd0);
    checkOutput("rx_ack_held", 200, 32'(rx_ack_moved), 32'd0);
    for (int i = 0; i < 10 && bus.rx_byte_ack_o != bus.rx_byte_tgl_i; i++) @(negedge clk);
    checkOutput("rx_ack_after_done", 200, 32'(bus.rx_byte_ack_o), 32'(bus.rx_byte_tgl_i));
    doReset(201);

    // Reset while the first byte of the second value is awaiting its ack.
    sendWord({vecs[0].start_v, vecs[0].end_v});
    sendWord({vecs[0].step_v, vecs[0].flags_v});
    runStream(0, 1'b0, 5);
    checkOutput("abort_reached", 300, 32'(byte_tgls), 32'd5);
    doReset(300);
    begin
      int late_tgls;
      late_tgls = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.tx_byte_tgl_o || bus.tx_word_tgl_o || bus.busy_o) late_tgls++;
      end
      checkOutput("post_abort_quiet", 300, 32'(late_tgls), 32'd0);
    end
    applyStimulus(vecs[0]);
    checkCommand(vecs[0], 301);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flicker_range_engine.md
FLICKER_RANGE_ENGINE -- requirements
Module: flicker_range_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of one GPIO byte lane.
REQ-002 SHALL have parameter WORD_BYTES, default 4, bytes per word, transferred MSB-first; W = DATA_W*WORD_BYTES SHALL be >= 2*CNT_W.
REQ-003 SHALL have parameter CNT_W, default 16, width of range values.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 rx_data_i  in  DATA_W  host-to-engine byte.
REQ-007 rx_byte_tgl_i  in  1  host toggles once per new rx byte.
REQ-008 rx_byte_ack_o  out  1  engine toggles once per consumed rx byte.
REQ-009 rx_word_ack_o  out  1  engine toggles once per completed rx word.
REQ-010 tx_data_o  out  DATA_W  engine-to-host byte.
REQ-011 tx_byte_tgl_o  out  1  engine toggles once per new tx byte.
REQ-012 tx_byte_ack_i  in  1  host toggles once per consumed tx byte.
REQ-013 tx_word_tgl_o  out  1  engine toggles once per completed tx word.
REQ-014 busy_o  out  1  high in every state except RX_A.
REQ-015 done_o  out  1  one-cycle pulse at end of each command.
REQ-016 emitted_o  out  CNT_W+1  values emitted by current/last command.

Function
REQ-017 States: RX_A, RX_B, CHECK, SEND, WAIT_ACK, NEXT, DONE.
REQ-018 rx event: rx_byte_tgl_i != rx_tgl_q (internal); accepted only in RX_A/RX_B; on accept edge byte shifts into assembly register, rx_tgl_q <= rx_byte_tgl_i, rx_byte_ack_o toggles.
REQ-019 rx event outside RX_A/RX_B SHALL remain pending (no ack, no data loss of toggle) and be accepted once engine returns to RX_A.
REQ-020 After WORD_BYTES accepted bytes, rx_word_ack_o toggles on the same edge as the last rx_byte_ack_o toggle; RX_A->RX_B, RX_B->CHECK.
REQ-021 Word A low 2*CNT_W bits = {start, end}; word B low 2*CNT_W bits = {step, flags}; flags[0]=dir (0 up, 1 down), flags[1]=inclusive; other bits ignored.
REQ-022 step==0 SHALL be treated as step 1.
REQ-023 Value v valid when: up exclusive v<end, up inclusive v<=end, down exclusive v>end, down inclusive v>=end; unsigned compare.
REQ-024 CHECK: v<=start, emitted_o<=0; if start valid -> SEND else -> DONE.
REQ-025 SEND: tx_data_o <= next byte of zero-extended v (W bits, MSB first), tx_byte_tgl_o toggles, -> WAIT_ACK.
REQ-026 WAIT_ACK: byte consumed when tx_byte_ack_i == tx_byte_tgl_o; tx_data_o SHALL hold stable until then; if more bytes -> SEND, else tx_word_tgl_o toggles, emitted_o increments, -> NEXT.
REQ-027 NEXT: next = v+step (up) or v-step (down) computed in CNT_W+1 bits; if carry/borrow out or next not valid -> DONE, else v<=next, -> SEND. No wrap-around SHALL occur.
REQ-028 DONE: done_o high for exactly this one cycle; -> RX_A; emitted_o holds until next CHECK.
REQ-029 First tx_byte_tgl_o toggle SHALL occur 2 edges after the edge accepting the last byte of word B (CHECK, SEND).

Reset
REQ-030 While rst_n low at an edge: state RX_A; all toggle outputs 0; tx_data_o 0; busy_o 0; done_o 0; emitted_o 0; rx_tgl_q <= rx_byte_tgl_i (no spurious event); partial word discarded.
REQ-031 Reset mid-command SHALL abort without any further tx toggle; host and engine both restart from toggle level 0.

Verification
REQ-032 A={0x0003,0x0006}, B={0x0001,0x0000} -> tx bytes 00 00 00 03, 00 00 00 04, 00 00 00 05; 12 byte toggles, 3 word toggles; done_o one pulse; emitted_o=3.
REQ-033 A={0x000A,0x0004}, B={0x0003,0x0003} (down, inclusive) -> emits 10, 7, 4; emitted_o=3.
REQ-034 A={0xFFFE,0xFFFF}, B={0x0002,0x0002} -> emits 0xFFFE only, no wrap to 0x0000; emitted_o=1.
REQ-035 A={0x0005,0x0005}, B={0x0000,0x0000} -> no tx toggles, done_o pulse, emitted_o=0; same with step 0 and end 0x0007 -> emits 5, 6.
REQ-036 Host delays tx_byte_ack_i 10 cycles and sends rx byte during streaming -> tx_data_o/tx_byte_tgl_o stable for 10 cycles; rx_byte_ack_o unchanged until after done_o, then toggles.
REQ-037 rst_n low one cycle during WAIT_ACK of second value -> all outputs at reset values next cycle; subsequent full command per REQ-032 passes.
